uart_rx_os16: RTL and testbench
===============================

Name: uart_rx_os16

Overview:
- Synthesizable UART receiver (8N1) for the SoC debug/console path. It is the receive end of the same serial link that the simulation UART model drives at 38400 baud.
- Recovers bytes from the asynchronous serial input using a 16x oversampling tick derived from the system clock.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream to the bus-side register interface.

Parameters:
- CLK_DIV, 163: system clock cycles per oversample tick, equal to clk/(16*baud). The default gives 38400 baud at 100 MHz. Legal range 2..255.
- DATA_BITS, 8: data bits per frame, sent LSB first.
- FIFO_DEPTH, 4: receive buffer entries. Must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_i  in  1  serial input; idle is high; asynchronous to clk
- data_o  out  DATA_BITS  head-of-FIFO byte
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: byte dropped because FIFO full
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0, FIFO empty, state IDLE, synchronizer flops 1. Reset mid-frame aborts the frame; no partial byte is ever pushed.
- Input conditioning: rx_i passes through a 2-flop synchronizer to rx_s. All decisions use rx_s only.
- Tick generator: counter 0..CLK_DIV-1. tick=1 in the cycle the counter equals CLK_DIV-1, then the counter wraps to 0. The counter is cleared on leaving IDLE. Let T0 be the cycle in which the FSM leaves IDLE; tick k then occurs at cycle T0 + k*CLK_DIV.
- sample counter (8 bits) increments on each tick and is cleared on leaving IDLE.
- FSM states and transitions:
  - IDLE: when rx_s==0, go to START.
  - START: at tick 8 (mid start bit), if rx_s==1 it is a false start: go to IDLE with no flags. Otherwise go to DATA.
  - DATA: bit i (i=0..DATA_BITS-1) is sampled at tick 8+16*(i+1) and shifted in LSB first. After the last bit, go to STOP.
  - STOP: sampled at tick 8+16*(DATA_BITS+1), which is tick 152 for 8 bits.
    - rx_s==1: push the byte and go to IDLE. Frame resynchronization can occur from mid-stop bit.
    - rx_s==0: pulse frame_err_o, discard the byte, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err pulse.
- Push timing: the push occurs in the stop-sample cycle, so valid_o rises the following cycle if the FIFO was empty.
- FIFO:
  - data_o reflects the head entry. Pop occurs when valid_o && ready_i.
  - Push when full without a simultaneous pop: pulse overrun_o, drop the new byte, keep the old contents.
  - Push when full with a simultaneous pop: the push is accepted and overrun_o is not asserted.
  - Push when empty: the byte appears on data_o the next cycle; there is no fall-through in the same cycle.
  - Pointers are log2(FIFO_DEPTH) bits wide plus one wrap bit, and wrap modulo the depth.
- frame_err_o and overrun_o are registered, high for exactly one cycle, and never both high in the same cycle.
- Clock tolerance: a sender baud error up to ±3% must still yield correct bytes.

Decomposition:
- uart_rx_pkg holds:
  - OVERSAMPLE=16 and SAMPLE_MID=8
  - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t
  - a function computing the stop-sample tick index from DATA_BITS
- One sub-module, uart_rx_fifo: a synchronous FIFO with push/pop/full/empty and the same clk/rstn. The top level holds the synchronizer, tick generator, FSM and shift register.

Test Plan:
- Clean frame: CLK_DIV=163, drive 0xA5 as 8N1 at 2608 cycles/bit -> valid_o rises 152*163+1 cycles after T0 with data_o=0xA5. No flags.
- Glitch: low pulse of 1000 cycles (shorter than 8*163) -> busy_o rises then falls. No valid_o, no frame_err_o.
- Framing error: 0x3C with stop bit low and the line held low for 3 bit times -> exactly one frame_err_o pulse and no byte. A following 0x55 on an idle line is received correctly.
- Overrun: with ready_i=0, send 0x01..0x05 -> overrun_o pulses once (on 0x05). Draining then yields 0x01, 0x02, 0x03, 0x04 in order. Repeat with ready_i=1 pulsed in the fifth stop-sample cycle -> no overrun.
- Reset mid-frame: assert rstn low during data bit 3 of 0xFF -> all outputs 0 immediately. After release and one idle bit time, 0x81 is received cleanly.
- Baud skew: 16 back-to-back random bytes at bit periods of 2530 and 2686 cycles (±3%) -> all bytes received in order with no flags.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants, state encoding and frame timing for the 16x oversampling UART receiver.
package uart_rx_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
    // Tick index at which the stop bit is sampled (mid-bit after start + data bits).
    function automatic int stop_tick(input int data_bits);
        return SAMPLE_MID + OVERSAMPLE * (data_bits + 1);
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];
    // Storage is reset so the head output reads zero while in reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver with 16x oversampling, mid-bit sampling and a small receive FIFO.
module uart_rx_os16 import uart_rx_pkg::*; #(
    parameter int CLK_DIV    = 163,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [7:0] STOP_IDX = 8'(stop_tick(DATA_BITS));
    uart_rx_state_t state, state_nx;
    logic sync1, rx_s;
    logic [CW-1:0] div_cnt;
    logic [7:0] samp_cnt, idx;
    logic [BW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic tick, shift, push, ferr, full, empty, pop;
    assign tick    = div_cnt == CW'(CLK_DIV - 1);
    assign idx     = samp_cnt + 8'd1;
    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    assign busy_o  = state != IDLE;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) {sync1, rx_s} <= 2'b11;
        else       {sync1, rx_s} <= {rx_i, sync1};
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        shift    = 1'b0;
        push     = 1'b0;
        ferr     = 1'b0;
        case (state)
            IDLE:  if (!rx_s) state_nx = START;
            START: if (tick && idx == 8'(SAMPLE_MID)) state_nx = rx_s ? IDLE : DATA;
            DATA:  if (tick && idx[3:0] == 4'(SAMPLE_MID)) begin
                       shift = 1'b1;
                       if (bit_cnt == BW'(DATA_BITS - 1)) state_nx = STOP;
                   end
            STOP:  if (tick && idx == STOP_IDX) begin
                       push     = rx_s;
                       ferr     = !rx_s;
                       state_nx = rx_s ? IDLE : BREAK;
                   end
            BREAK: if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Timing counters are held at zero in IDLE, which also clears them on the start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt     <= '0;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            div_cnt     <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
            samp_cnt    <= state == IDLE ? '0 : samp_cnt + 8'(tick);
            bit_cnt     <= state != DATA ? '0 : bit_cnt + BW'(shift);
            shreg       <= shift ? {rx_s, shreg[DATA_BITS-1:1]} : shreg;
            frame_err_o <= ferr;
            overrun_o   <= push && full && !pop;
        end
    end
    uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (data_o),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: drives serial frames into uart_rx_os16 and checks bytes and flags against a transaction-level model.
module tb_uart_rx_os16;
    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT        = 16 * CLK_DIV;
    logic clk = 1'b0, rstn = 1'b0, rx_i = 1'b1, ready_i = 1'b0;
    logic [7:0] data_o;
    logic valid_o, frame_err_o, overrun_o, busy_o;
    int checks = 0, failures = 0;
    int cyc = 0, ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, busy_rises = 0;
    int busy_rise_cyc = 0, valid_rise_cyc = 0;
    logic busy_q = 1'b0, valid_q = 1'b0;
    logic [7:0] rx_q[$], exp_q[$];

    uart_rx_os16 #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled mid-cycle; records accepted bytes, flag pulses and edge times.
    always @(negedge clk) begin
        if (valid_o && ready_i) rx_q.push_back(data_o);
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
        if (frame_err_o && overrun_o) both_cnt++;
        if (busy_o && !busy_q) begin busy_rises++; busy_rise_cyc = cyc; end
        if (valid_o && !valid_q) valid_rise_cyc = cyc;
        busy_q  = busy_o;
        valid_q = valid_o;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bitp, input logic stop_val);
        rx_i = 1'b0;
        cycles(bitp);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            cycles(bitp);
        end
        rx_i = stop_val;
        cycles(bitp);
    endtask

    task automatic test_reset;
        rstn = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
        cycles(3);
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %0h expected 0", data_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
        checks++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin failures++; $display("FAIL reset_flags: got ferr=%0b ovr=%0b expected 0 0", frame_err_o, overrun_o); end
        rstn = 1'b1;
        cycles(BIT);
    endtask

    task automatic test_clean;
        int f0, o0;
        logic [7:0] b;
        f0 = ferr_cnt; o0 = ovr_cnt;
        ready_i = 1'b1;
        rx_q.delete(); exp_q.delete();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, BIT, 1'b1);
        checks++; if (valid_rise_cyc - busy_rise_cyc !== 152 * CLK_DIV) begin failures++; $display("FAIL clean_latency: got %0d expected %0d", valid_rise_cyc - busy_rise_cyc, 152 * CLK_DIV); end
        cycles(BIT);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, BIT, 1'b1);
            cycles($urandom_range(1, BIT));
        end
        cycles(BIT);
        checks++; if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL clean_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL clean_byte%0d: got %0h expected %0h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (ferr_cnt !== f0 || ovr_cnt !== o0) begin failures++; $display("FAIL clean_flags: got ferr=%0d ovr=%0d expected %0d %0d", ferr_cnt, ovr_cnt, f0, o0); end
    endtask

    task automatic test_glitch;
        int r0, f0, len;
        rx_q.delete();
        f0 = ferr_cnt;
        for (int k = 0; k < 3; k++) begin
            r0 = busy_rises;
            len = $urandom_range(4, 8 * CLK_DIV - 8);
            rx_i = 1'b0;
            cycles(len);
            rx_i = 1'b1;
            cycles(2 * BIT);
            checks++; if (busy_rises !== r0 + 1) begin failures++; $display("FAIL glitch_busy_rise len=%0d: got %0d expected %0d", len, busy_rises - r0, 1); end
            checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL glitch_busy_end len=%0d: got %0b expected 0", len, busy_o); end
        end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL glitch_bytes: got %0d expected 0", rx_q.size()); end
        checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt - f0, 0); end
    endtask

    task automatic test_frame_err;
        int f0, o0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        ready_i = 1'b1;
        rx_q.delete();
        send_frame(8'h3C, BIT, 1'b0);
        cycles(3 * BIT);
        rx_i = 1'b1;
        cycles(BIT);
        checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL ferr_discard: got %0d bytes expected 0", rx_q.size()); end
        send_frame(8'h55, BIT, 1'b1);
        cycles(BIT);
        checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL ferr_next_count: got %0d expected 1", rx_q.size()); end
        else begin checks++; if (rx_q[0] !== 8'h55) begin failures++; $display("FAIL ferr_next_byte: got %0h expected 55", rx_q[0]); end end
        checks++; if (ferr_cnt !== f0 + 1 || ovr_cnt !== o0) begin failures++; $display("FAIL ferr_after: got ferr=%0d ovr=%0d expected 1 0", ferr_cnt - f0, ovr_cnt - o0); end
    endtask

    task automatic test_overrun;
        int o0, exp_ovr, k;
        logic [7:0] fifo_m[$];
        logic [7:0] b[5];
        // Round 1: consumer stalled, fifth byte must be dropped.
        ready_i = 1'b0;
        rx_q.delete(); exp_q.delete();
        o0 = ovr_cnt; exp_ovr = 0;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'(i + 1), BIT, 1'b1);
            cycles(BIT);
            if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(8'(i + 1));
            else exp_ovr++;
        end
        checks++; if (ovr_cnt - o0 !== exp_ovr) begin failures++; $display("FAIL ovr_pulses: got %0d expected %0d", ovr_cnt - o0, exp_ovr); end
        checks++; if (valid_o !== 1'b1 || data_o !== fifo_m[0]) begin failures++; $display("FAIL ovr_head: got v=%0b d=%0h expected 1 %0h", valid_o, data_o, fifo_m[0]); end
        ready_i = 1'b1;
        cycles(FIFO_DEPTH + 2);
        ready_i = 1'b0;
        checks++; if (rx_q.size() !== fifo_m.size()) begin failures++; $display("FAIL ovr_drain_count: got %0d expected %0d", rx_q.size(), fifo_m.size()); end
        for (int i = 0; i < fifo_m.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== fifo_m[i]) begin failures++; $display("FAIL ovr_drain%0d: got %0h expected %0h", i, rx_q[i], fifo_m[i]); end
        end
        // Round 2: a pop in the fifth stop-sample cycle makes room for the push.
        rx_q.delete(); fifo_m.delete();
        o0 = ovr_cnt;
        foreach (b[i]) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            send_frame(b[i], BIT, 1'b1);
            cycles(BIT);
            fifo_m.push_back(b[i]);
        end
        fork
            send_frame(b[4], BIT, 1'b1);
            begin
                k = 0;
                while (!busy_o && k < BIT) begin cycles(1); k++; end
                checks++;
                if (!busy_o) begin failures++; $display("FAIL ovr_wait_busy: got busy=0 expected 1 within %0d cycles", BIT); end
                else begin
                    cycles(152 * CLK_DIV - 1);
                    ready_i = 1'b1;
                    cycles(1);
                    ready_i = 1'b0;
                end
            end
        join
        exp_q.push_back(fifo_m.pop_front());
        fifo_m.push_back(b[4]);
        cycles(BIT);
        checks++; if (ovr_cnt !== o0) begin failures++; $display("FAIL ovr_simul_pop: got %0d pulses expected 0", ovr_cnt - o0); end
        ready_i = 1'b1;
        cycles(FIFO_DEPTH + 2);
        foreach (fifo_m[i]) exp_q.push_back(fifo_m[i]);
        checks++; if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovr2_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovr2_byte%0d: got %0h expected %0h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        ready_i = 1'b0;
        rx_q.delete();
        send_frame(8'($urandom), BIT, 1'b1);
        cycles(BIT);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid: got %0b expected 1", valid_o); end
        fork
            send_frame(8'hFF, BIT, 1'b1);
            begin
                cycles(4 * BIT + BIT / 2);
                checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre_busy: got %0b expected 1", busy_o); end
                rstn = 1'b0;
                #1;
                checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl: got busy=%0b valid=%0b expected 0 0", busy_o, valid_o); end
                checks++; if (data_o !== 8'h00 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin failures++; $display("FAIL rstmid_out: got d=%0h ferr=%0b ovr=%0b expected 0 0 0", data_o, frame_err_o, overrun_o); end
            end
        join
        rstn = 1'b1;
        cycles(BIT);
        ready_i = 1'b1;
        send_frame(8'h81, BIT, 1'b1);
        cycles(BIT);
        checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL rstmid_count: got %0d expected 1", rx_q.size()); end
        else begin checks++; if (rx_q[0] !== 8'h81) begin failures++; $display("FAIL rstmid_byte: got %0h expected 81", rx_q[0]); end end
    endtask

    task automatic test_baud_skew;
        int f0, o0, p;
        logic [7:0] b;
        ready_i = 1'b1;
        for (int r = 0; r < 2; r++) begin
            p = r == 0 ? BIT - 2 : BIT + 2;
            f0 = ferr_cnt; o0 = ovr_cnt;
            rx_q.delete(); exp_q.delete();
            for (int i = 0; i < 16; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                send_frame(b, p, 1'b1);
            end
            cycles(2 * BIT);
            checks++; if (rx_q.size() !== 16) begin failures++; $display("FAIL skew%0d_count: got %0d expected 16", p, rx_q.size()); end
            for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
                checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL skew%0d_byte%0d: got %0h expected %0h", p, i, rx_q[i], exp_q[i]); end
            end
            checks++; if (ferr_cnt !== f0 || ovr_cnt !== o0) begin failures++; $display("FAIL skew%0d_flags: got ferr=%0d ovr=%0d expected 0 0", p, ferr_cnt - f0, ovr_cnt - o0); end
        end
    endtask

    task automatic test_flag_exclusive;
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL flags_exclusive: got %0d overlapping cycles expected 0", both_cnt); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_reset_mid;
        test_baud_skew;
        test_flag_exclusive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
